// File: rtl/hny_message_scroller.sv
// Steps through "HAPPY NEW YEAR 2026" on a prescaled tick and drives 7-segment codes.
// Optional end-of-message blink on the final "6" is enabled by defining HNY_END_BLINK_EN.
module hny_message_scroller #(
    parameter int PRESCALE = 10_000_000,
    parameter int MSG_LEN  = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] speed,
    input  logic       pause,
    input  logic       step,
    output logic [7:0] seg,
    output logic [4:0] char_idx,
    output logic       frame_end
);

    localparam logic [4:0] LAST_IDX = 5'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSE
`ifdef HNY_END_BLINK_EN
        , ST_BLINK
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [26:0] pc_q, pc_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  seg_q, seg_d;
    logic        fe_q, fe_d;
    logic        step_q, step_prev_q;
    logic [26:0] div;
    logic        tick;
    logic        step_rise;
    logic        adv;
`ifdef HNY_END_BLINK_EN
    logic [1:0]  blk_q, blk_d;
`endif

    function automatic logic [6:0] font(input logic [4:0] i);
        case (i)
            5'd0:    font = 7'h76;
            5'd1:    font = 7'h77;
            5'd2:    font = 7'h73;
            5'd3:    font = 7'h73;
            5'd4:    font = 7'h6E;
            5'd5:    font = 7'h00;
            5'd6:    font = 7'h54;
            5'd7:    font = 7'h79;
            5'd8:    font = 7'h3E;
            5'd9:    font = 7'h00;
            5'd10:   font = 7'h6E;
            5'd11:   font = 7'h79;
            5'd12:   font = 7'h77;
            5'd13:   font = 7'h50;
            5'd14:   font = 7'h00;
            5'd15:   font = 7'h5B;
            5'd16:   font = 7'h3F;
            5'd17:   font = 7'h5B;
            5'd18:   font = 7'h7D;
            default: font = 7'h00;
        endcase
    endfunction

    // ">=" rather than "==" so a speed change that leaves pc past the new limit still ticks.
    always_comb begin
        div = 27'(PRESCALE >> speed);
        if (div == 27'd0) div = 27'd1;
        tick      = (pc_q >= (div - 27'd1));
        step_rise = step_q & ~step_prev_q;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        fe_d    = 1'b0;
        adv     = 1'b0;
`ifdef HNY_END_BLINK_EN
        blk_d   = blk_q;
`endif
        if (pause) begin
            adv = step_rise;
            if (state_q == ST_RUN) state_d = ST_PAUSE;
        end else begin
            adv  = tick;
            pc_d = tick ? 27'd0 : pc_q + 27'd1;
            if (state_q == ST_PAUSE) state_d = ST_RUN;
        end

`ifdef HNY_END_BLINK_EN
        // Blink phases count 1..3 lit/dark, the 4th event leaves for index 0.
        if (state_q == ST_BLINK) begin
            if (adv) begin
                if (blk_q == 2'd3) begin
                    state_d = pause ? ST_PAUSE : ST_RUN;
                    idx_d   = 5'd0;
                    seg_d   = {1'b0, font(5'd0)};
                    fe_d    = 1'b1;
                    blk_d   = 2'd0;
                end else begin
                    blk_d = blk_q + 2'd1;
                    seg_d = blk_q[0] ? 8'h00 : 8'hFD;
                end
            end
        end else
`endif
        if (adv) begin
            if (idx_q == LAST_IDX) begin
`ifdef HNY_END_BLINK_EN
                state_d = ST_BLINK;
                seg_d   = 8'h00;
                blk_d   = 2'd0;
`else
                idx_d   = 5'd0;
                seg_d   = {1'b0, font(5'd0)};
                fe_d    = 1'b1;
`endif
            end else begin
                idx_d = idx_q + 5'd1;
                seg_d = {1'b0, font(idx_q + 5'd1)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= 27'd0;
            idx_q       <= 5'd0;
            seg_q       <= 8'h76;
            fe_q        <= 1'b0;
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
`ifdef HNY_END_BLINK_EN
            blk_q       <= 2'd0;
`endif
        end else begin
            fe_q <= ena & fe_d;
            if (ena) begin
                state_q     <= state_d;
                pc_q        <= pc_d;
                idx_q       <= idx_d;
                seg_q       <= seg_d;
                step_q      <= step;
                step_prev_q <= step_q;
`ifdef HNY_END_BLINK_EN
                blk_q       <= blk_d;
`endif
            end
        end
    end

    assign seg       = seg_q;
    assign char_idx  = idx_q;
    assign frame_end = fe_q;

endmodule

// File: tb/tb_hny_message_scroller.sv
// Bench for hny_message_scroller: slot-position reference model plus directed literal checks.
module tb_hny_message_scroller;

    localparam int PRE   = 8;
`ifdef HNY_END_BLINK_EN
    localparam int NSLOT = 23;
`else
    localparam int NSLOT = 19;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic [1:0] speed = 2'd1;
    logic       pause = 1'b0;
    logic       step  = 1'b0;
    logic [7:0] seg;
    logic [4:0] char_idx;
    logic       frame_end;

    always #5 clk = ~clk;

    hny_message_scroller #(.PRESCALE(PRE), .MSG_LEN(19)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .speed(speed), .pause(pause),
        .step(step), .seg(seg), .char_idx(char_idx), .frame_end(frame_end)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the message is a ring of NSLOT display slots; an event moves one slot.
    logic [6:0] rom [19] = '{7'h76, 7'h77, 7'h73, 7'h73, 7'h6E, 7'h00, 7'h54, 7'h79, 7'h3E,
                             7'h00, 7'h6E, 7'h79, 7'h77, 7'h50, 7'h00, 7'h5B, 7'h3F, 7'h5B, 7'h7D};
    int m_pc   = 0;
    int m_pos  = 0;
    bit m_fe   = 0;
    bit m_s0   = 0;
    bit m_s1   = 0;
    bit m_valid = 0;

    function automatic int e_idx();
        return (m_pos < 19) ? m_pos : 18;
    endfunction

    function automatic logic [7:0] e_seg();
        if (m_pos < 19) return {1'b0, rom[m_pos]};
        return ((m_pos - 19) % 2 == 1) ? 8'hFD : 8'h00;
    endfunction

    always @(posedge clk) begin
        int  div;
        bit  rise, ev;
        if (!rst_n) begin
            m_pc = 0; m_pos = 0; m_fe = 0; m_s0 = 0; m_s1 = 0; m_valid = 1;
        end else if (ena) begin
            rise = m_s0 && !m_s1;
            m_s1 = m_s0;
            m_s0 = step;
            div  = PRE >> speed;
            if (div < 1) div = 1;
            if (pause) ev = rise;
            else begin
                ev   = (m_pc >= div - 1);
                m_pc = ev ? 0 : m_pc + 1;
            end
            m_fe = 0;
            if (ev) begin
                m_pos = (m_pos + 1) % NSLOT;
                m_fe  = (m_pos == 0);
            end
        end else begin
            m_fe = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_seg", seg, e_seg());
            chk("model_idx", char_idx, e_idx());
            chk("model_fe", frame_end, m_fe);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then run at DIV=4
        cyc(3);
        chk("rst_seg", seg, 8'h76);
        chk("rst_idx", char_idx, 0);
        chk("rst_fe", frame_end, 0);
        rst_n = 1'b1;
        cyc(3);
        chk("c3_idx", char_idx, 0);
        cyc(1);
        chk("c4_idx", char_idx, 1);
        chk("c4_seg", seg, 8'h77);
        cyc(68);
        chk("c72_idx", char_idx, 18);
        chk("c72_seg", seg, 8'h7D);
        cyc(4);
`ifdef HNY_END_BLINK_EN
        chk("c76_idx", char_idx, 18);
        chk("c76_seg", seg, 8'h00);
        for (int p = 1; p < 4; p++) begin
            cyc(4);
            chk("blink_seg", seg, (p % 2 == 1) ? 8'hFD : 8'h00);
        end
        cyc(4);
        chk("c92_idx", char_idx, 0);
        chk("c92_seg", seg, 8'h76);
        chk("c92_fe", frame_end, 1);
`else
        chk("c76_idx", char_idx, 0);
        chk("c76_seg", seg, 8'h76);
        chk("c76_fe", frame_end, 1);
        cyc(1);
        chk("c77_fe", frame_end, 0);
`endif

        // Anchor reset, then speed switch from DIV=4 to DIV=1 with pc=1
        rst_n = 1'b0; speed = 2'd1;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        speed = 2'd3;
        cyc(1);
        chk("sw_idx", char_idx, 1);
        chk("sw_seg", seg, 8'h77);
        speed = 2'd2;
        cyc(1);
        chk("div2_hold", char_idx, 1);
        cyc(1);
        chk("div2_idx2", char_idx, 2);
        cyc(2);
        chk("div2_idx3", char_idx, 3);

        // Pause raised in the tick cycle, held 100 cycles
        speed = 2'd1;
        cyc(3);
        pause = 1'b1;
        cyc(100);
        chk("pause_idx", char_idx, 3);
        chk("pause_seg", seg, 8'h73);

        // Step pulses
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step_lat0", char_idx, 3);
        cyc(1);
        chk("step_lat1", char_idx, 4);
        cyc(2);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(3);
        chk("step2_idx", char_idx, 5);
        step = 1'b1;
        cyc(20);
        chk("step_hold_idx", char_idx, 6);
        chk("step_hold_seg", seg, 8'h54);
        step = 1'b0;
        cyc(3);
        chk("step_norpt", char_idx, 6);
        for (int i = 0; i < 6; i++) begin
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            cyc(1);
        end
        cyc(2);
        chk("step12_idx", char_idx, 12);
        chk("step12_seg", seg, 8'h77);

        // Reset while paused
        rst_n = 1'b0;
        cyc(1);
        chk("mrst_idx", char_idx, 0);
        chk("mrst_seg", seg, 8'h76);
        rst_n = 1'b1; pause = 1'b0;
        cyc(4);
        chk("mrst_run", char_idx, 1);

        // ena low mid-count with step toggling
        cyc(1);
        ena = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step = ~step;
            cyc(1);
        end
        chk("ena_idx", char_idx, 1);
        chk("ena_seg", seg, 8'h77);
        step = 1'b0; ena = 1'b1;
        cyc(2);
        chk("ena_pc_held", char_idx, 1);
        cyc(1);
        chk("ena_resume", char_idx, 2);

        // Speed 0, then a full period at DIV=4 through the wrap
        speed = 2'd0;
        cyc(40);
        speed = 2'd1;
        cyc(200);

        // Pause during the end of the message, stepping through it
        pause = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            cyc(1);
        end
        pause = 1'b0;
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
